// File: rtl/rr_lock_arb.sv
// Round-robin arbiter with grant locking. A registered one-hot grant is held
// until the owner releases it, drops its request, or reaches the hold limit.
module rr_lock_arb #(
  parameter  int width_p    = 8,
  parameter  int hold_max_p = 15,
  localparam int addr_w_lp  = $clog2(width_p),
  localparam int cnt_w_lp   = $clog2(hold_max_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [width_p-1:0]   reqs_i,
  input  logic                 release_i,
  output logic [width_p-1:0]   grants_o,
  output logic [addr_w_lp-1:0] addr_o,
  output logic                 v_o,
  output logic                 timeout_o,
  output logic                 state_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int sum_w_lp = addr_w_lp + 1;

  state_t               state_q, state_d;
  logic [addr_w_lp-1:0] ptr_q, ptr_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic [width_p-1:0]   grants_q, grants_d;
  logic [addr_w_lp-1:0] addr_q, addr_d;
  logic                 timeout_q, timeout_d;

  logic                 found;
  logic [addr_w_lp-1:0] sel;
  logic [sum_w_lp-1:0]  sum;
  logic                 rel_exit, drop_exit, hold_exit, busy_exit;

  // Scan ptr, ptr+1, ... with wrap; the first set request wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int i = 0; i < width_p; i++) begin
      sum = {1'b0, ptr_q} + sum_w_lp'(i);
      if (sum >= sum_w_lp'(width_p)) sum = sum - sum_w_lp'(width_p);
      if (!found && reqs_i[sum[addr_w_lp-1:0]]) begin
        found = 1'b1;
        sel   = sum[addr_w_lp-1:0];
      end
    end
  end

  assign rel_exit  = release_i;
  assign drop_exit = ~reqs_i[addr_q];
  assign hold_exit = (cnt_q == cnt_w_lp'(hold_max_p));
  assign busy_exit = rel_exit | drop_exit | hold_exit;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grants_q  <= '0;
      addr_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grants_q  <= grants_d;
      addr_q    <= addr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          cnt_d   = cnt_w_lp'(1);
        end
      end
      BUSY: begin
        if (busy_exit) begin
          state_d = IDLE;
          cnt_d   = '0;
          ptr_d   = (addr_q == addr_w_lp'(width_p - 1)) ? '0
                                                        : addr_q + addr_w_lp'(1);
        end else begin
          cnt_d = cnt_q + cnt_w_lp'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timeout only when the hold limit alone ends the grant.
  always_comb begin
    grants_d  = grants_q;
    addr_d    = addr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grants_d      = '0;
          grants_d[sel] = 1'b1;
          addr_d        = sel;
        end
      end
      BUSY: begin
        if (busy_exit) begin
          grants_d  = '0;
          addr_d    = '0;
          timeout_d = hold_exit & ~rel_exit & ~drop_exit;
        end
      end
      default: begin
        grants_d = '0;
        addr_d   = '0;
      end
    endcase
  end

  assign grants_o  = grants_q;
  assign addr_o    = addr_q;
  assign v_o       = |grants_q;
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule

// File: doc/rr_lock_arb.md
Name: rr_lock_arb

Overview:
- Round-robin arbiter with grant locking that shares one resource (bus, encoder datapath, memory port) among width_p requesters.
- Issues a registered one-hot grant plus its binary index, the same encoding the team's one-hot encoders produce.
- Holds the grant until the owner releases it, drops its request, or hits a hold-time limit.
- Sits between the requester clients and the shared datapath's select/valid inputs.

Parameters:
- width_p, 8: number of requesters; legal range 2 or more.
- hold_max_p, 15: maximum consecutive cycles a single grant may be held before forced release; legal range 1 or more.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- reqs_i  input  width_p  request vector, one bit per requester; multiple bits may be set.
- release_i  input  1  owner finished; sampled only in BUSY.
- grants_o  output  width_p  registered grant; one-hot or all-zero.
- addr_o  output  $clog2(width_p)  binary index of the set bit of grants_o; 0 when grants_o is 0.
- v_o  output  1  equals |grants_o.
- timeout_o  output  1  one-cycle pulse marking a forced release.

Behaviour:
- Reset (reset_n_i=0, asynchronous, takes effect immediately, including mid-grant):
  - grants_o=0, addr_o=0, v_o=0, timeout_o=0.
  - state=IDLE, priority pointer ptr=0, hold counter=0.
- Internal state:
  - ptr, width $clog2(width_p): highest-priority index.
  - hold counter, width $clog2(hold_max_p+1): counts cycles the current grant has been visible.
- IDLE (grants_o=0):
  - If reqs_i is non-zero at the clock edge, select the first set bit scanning ptr, ptr+1, ..., width_p-1, 0, ..., ptr-1 (wrap-around).
  - At that edge: register grants_o=1<<sel and addr_o=sel, set counter=1, go to BUSY.
  - Latency: grant is visible on the cycle after the request is sampled.
  - If reqs_i=0: stay in IDLE.
  - release_i is ignored in IDLE.
- BUSY (grants_o one-hot, owner = addr_o):
  - Requests from non-owners are ignored; no preemption.
  - Exit conditions, evaluated at each edge:
    - (a) release_i=1.
    - (b) reqs_i[owner]=0.
    - (c) counter==hold_max_p.
  - On exit:
    - Next cycle grants_o=0, addr_o=0, v_o=0.
    - ptr=(owner+1) mod width_p.
    - state=IDLE.
    - counter=0.
  - Otherwise: counter increments and the grant is held unchanged.
- Grant length: a grant is visible for at most hold_max_p consecutive cycles.
- Forced release:
  - Occurs on exit by (c) only, with neither (a) nor (b) true in the same cycle.
  - timeout_o=1 during the first IDLE cycle after exit, for exactly one cycle.
  - Otherwise timeout_o=0.
- Simultaneous exit events: (a) or (b) take precedence over (c); no timeout pulse is issued.
- Handover: there is always exactly one bubble cycle (grants_o=0) between consecutive grants, even to the same requester.
  - The IDLE cycle arbitrates; the new grant appears on the following cycle.
  - Minimum period between grant starts is 2 cycles.
- Invariants:
  - grants_o never has more than one bit set.
  - addr_o is always consistent with grants_o.
- Reset released mid-stream: arbitration restarts from ptr=0 on the first edge after deassertion.

Test Plan:
- Reset hold: reset_n_i=0, reqs_i=8'hFF, random release_i
  -> grants_o=0, addr_o=0, v_o=0, timeout_o=0 throughout.
  - First grant after deassert: grants_o=8'h01, addr_o=0.
- Round-robin rotation: from reset, reqs_i=8'h05; assert release_i for 1 cycle 3 cycles after each grant appears.
  - Grant order: 8'h01 (addr 0), 8'h04 (addr 2), 8'h01, 8'h04.
  - Each grant is separated by exactly one zero cycle.
- Wrap-around: grant requester 7 alone (reqs_i=8'h80), release, then reqs_i=8'h81
  -> next grant 8'h01, addr_o=0 (ptr wrapped to 0).
- Timeout: hold_max_p=15, reqs_i=8'h08 held, release_i=0
  -> grants_o=8'h08 for exactly 15 cycles.
  - Then one cycle of grants_o=0 with timeout_o=1.
  - Then grants_o=8'h08 again with timeout_o=0.
  - Same run, but with release_i=1 on the 15th grant cycle -> timeout_o stays 0.
- Request drop: requester 4 granted (8'h10); on grant cycle 2, reqs_i=8'h0
  -> grants_o=0 on the next cycle, timeout_o=0, ptr=5.
  - Then reqs_i=8'h30 -> grant 8'h20 (addr 5).
- Async reset mid-grant: grants_o=8'h40 held; pulse reset_n_i low between clock edges
  -> grants_o, addr_o, v_o go to 0 immediately, without waiting for an edge.
  - After release with reqs_i=8'h41 -> grant 8'h01 (ptr back to 0).
